// File: rtl/pipe_pkg.sv
// Shared definitions for the execute-stage pipeline sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // Default geometry of the pipeline control block.
    localparam int PIPE_REG_AW      = 4;
    localparam int PIPE_SR_W        = 4;
    localparam int PIPE_MEM_TIMEOUT = 15;

    // Status register bit positions, ordered {N,Z,C,V} from MSB to LSB.
    // The EXE stage takes its carry-in from sr[SR_C].
    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    // Data-memory access sequencer states.
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    // Pipeline steering bundle produced by the priority mux.
    typedef struct packed {
        logic pc_freeze;
        logic ifid_freeze;
        logic ifid_flush;
        logic idexe_bubble;
        logic pipe_freeze;
    } pipe_ctl_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Sequences one multi-cycle data-memory access: launch pulse, wait, one-cycle release.
// Latency: access occupies (wait cycles + 2) cycles; launch pulse is combinational on mem_req in IDLE.
// Backpressure: mem_freeze holds the whole pipe from launch until the DONE cycle.
module mem_wait_fsm
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = PIPE_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic sram_done,
    output logic sram_start,
    output logic mem_freeze,
    output logic mem_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // State, wait counter and sticky error; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: DONE is always followed by IDLE, so mem_req is not re-sampled there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            MEM_IDLE: begin
                if (mem_req) begin
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            MEM_WAIT: begin
                if (sram_done) begin
                    state_d = MEM_DONE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = MEM_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEM_DONE: begin
                state_d = MEM_IDLE;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    // Outputs: launch only from IDLE; the freeze covers the launch cycle and all of WAIT.
    always_comb begin
        sram_start = (state_q == MEM_IDLE) && mem_req;
        mem_freeze = (state_q == MEM_WAIT) || sram_start;
        mem_err    = err_q;
    end

endmodule

// File: rtl/exe_pipe_ctrl.sv
// Pipeline sequencer beside EXE: status register, RAW stall, branch flush, memory-wait freeze.
// Latency: steering outputs are combinational; sr updates one edge after a qualifying exe_s.
// Backpressure: memory freeze outranks branch flush, which outranks hazard stall.
module exe_pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW      = PIPE_REG_AW,
    parameter int SR_W        = PIPE_SR_W,
    parameter int MEM_TIMEOUT = PIPE_MEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_s,
    input  logic [SR_W-1:0]   alu_status,
    input  logic              br_taken,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              mem_req,
    input  logic              sram_done,
    output logic [SR_W-1:0]   sr,
    output logic              sram_start,
    output logic              pc_freeze,
    output logic              ifid_freeze,
    output logic              ifid_flush,
    output logic              idexe_bubble,
    output logic              pipe_freeze,
    output logic              mem_err
);

    logic            mem_freeze;
    logic            hazard;
    logic [SR_W-1:0] sr_q, sr_d;
    pipe_ctl_t       ctl;

    mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .sram_done  (sram_done),
        .sram_start (sram_start),
        .mem_freeze (mem_freeze),
        .mem_err    (mem_err)
    );

    // RAW detection against both in-flight producers; no forwarding, so any match stalls.
    always_comb begin
        logic src1_hit;
        logic src2_hit;
        src1_hit = (exe_wb_en && (exe_dest == id_src1)) || (mem_wb_en && (mem_dest == id_src1));
        src2_hit = (exe_wb_en && (exe_dest == id_src2)) || (mem_wb_en && (mem_dest == id_src2));
        hazard   = id_valid && (src1_hit || (id_two_src && src2_hit));
    end

    // Priority mux: memory freeze, then taken branch, then hazard stall.
    // A branch held under freeze stays on br_taken and is acted on in the release cycle.
    always_comb begin
        ctl = '0;
        if (mem_freeze) begin
            ctl.pc_freeze   = 1'b1;
            ctl.ifid_freeze = 1'b1;
            ctl.pipe_freeze = 1'b1;
        end else if (br_taken) begin
            ctl.ifid_flush   = 1'b1;
            ctl.idexe_bubble = 1'b1;
        end else if (hazard) begin
            ctl.pc_freeze    = 1'b1;
            ctl.ifid_freeze  = 1'b1;
            ctl.idexe_bubble = 1'b1;
        end
    end

    // SR load: a flag-setting instruction frozen in EXE writes once, on the release edge.
    always_comb begin
        sr_d = sr_q;
        if (exe_s && !mem_freeze) begin
            sr_d = alu_status;
        end
    end

    // Status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Drive outputs.
    always_comb begin
        sr           = sr_q;
        pc_freeze    = ctl.pc_freeze;
        ifid_freeze  = ctl.ifid_freeze;
        ifid_flush   = ctl.ifid_flush;
        idexe_bubble = ctl.idexe_bubble;
        pipe_freeze  = ctl.pipe_freeze;
    end

endmodule

// File: tb/tb_exe_pipe_ctrl.sv
// Self-checking bench for exe_pipe_ctrl: per-cycle expectations queued as stimulus is driven.
// Latency: outputs sampled on the falling edge of each stimulus cycle.
// Backpressure: n/a.
module tb_exe_pipe_ctrl;

    typedef struct packed {
        logic       rst_n;
        logic       id_valid;
        logic [3:0] id_src1;
        logic [3:0] id_src2;
        logic       id_two_src;
        logic [3:0] exe_dest;
        logic       exe_wb_en;
        logic       exe_s;
        logic [3:0] alu_status;
        logic       br_taken;
        logic [3:0] mem_dest;
        logic       mem_wb_en;
        logic       mem_req;
        logic       sram_done;
    } in_t;

    typedef struct packed {
        logic [3:0] sr;
        logic       sram_start;
        logic       pc_freeze;
        logic       ifid_freeze;
        logic       ifid_flush;
        logic       idexe_bubble;
        logic       pipe_freeze;
        logic       mem_err;
    } out_t;

    // Flag groups in out_t order {start, pcf, iff, flush, bubble, pipe_freeze, err}.
    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_START = 7'b1110010;
    localparam logic [6:0] O_FRZ   = 7'b0110010;
    localparam logic [6:0] O_STALL = 7'b0110100;
    localparam logic [6:0] O_FLUSH = 7'b0001100;
    localparam logic [6:0] O_ERR   = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_two_src, exe_wb_en, exe_s, br_taken, mem_wb_en, mem_req, sram_done;
    logic [3:0] id_src1, id_src2, exe_dest, alu_status, mem_dest;
    logic [3:0] sr;
    logic       sram_start, pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, pipe_freeze, mem_err;

    out_t sb[$];
    out_t obs_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    exe_pipe_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_s        (exe_s),
        .alu_status   (alu_status),
        .br_taken     (br_taken),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .mem_req      (mem_req),
        .sram_done    (sram_done),
        .sr           (sr),
        .sram_start   (sram_start),
        .pc_freeze    (pc_freeze),
        .ifid_freeze  (ifid_freeze),
        .ifid_flush   (ifid_flush),
        .idexe_bubble (idexe_bubble),
        .pipe_freeze  (pipe_freeze),
        .mem_err      (mem_err)
    );

    function automatic in_t idle();
        in_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic out_t ex(input logic [3:0] e_sr, input logic [6:0] flags);
        return out_t'({e_sr, flags});
    endfunction

    function automatic out_t sample();
        return out_t'({sr, sram_start, pc_freeze, ifid_freeze, ifid_flush,
                       idexe_bubble, pipe_freeze, mem_err});
    endfunction

    task automatic drive(input in_t s);
        rst_n      = s.rst_n;
        id_valid   = s.id_valid;
        id_src1    = s.id_src1;
        id_src2    = s.id_src2;
        id_two_src = s.id_two_src;
        exe_dest   = s.exe_dest;
        exe_wb_en  = s.exe_wb_en;
        exe_s      = s.exe_s;
        alu_status = s.alu_status;
        br_taken   = s.br_taken;
        mem_dest   = s.mem_dest;
        mem_wb_en  = s.mem_wb_en;
        mem_req    = s.mem_req;
        sram_done  = s.sram_done;
    endtask

    // One clock cycle: drive just after the rising edge, queue the expectation, sample at the fall.
    task automatic step(input in_t s, input out_t e);
        @(posedge clk);
        #1;
        drive(s);
        sb.push_back(e);
        @(negedge clk);
        obs_q.push_back(sample());
    endtask

    task automatic test_reset();
        in_t s;
        out_t e, o;
        int n = 0;
        s = idle(); s.rst_n = 1'b0;                      step(s, ex(4'h0, O_NONE));
        s = idle(); s.exe_s = 1'b1; s.alu_status = 4'h9; step(s, ex(4'h0, O_NONE));
        s = idle(); s.mem_req = 1'b1;                    step(s, ex(4'h9, O_START));
        for (int i = 0; i < 6; i++) step(s, ex(4'h9, O_FRZ));   // WAIT, counter 0..5
        s = idle(); s.rst_n = 1'b0;                      step(s, ex(4'h0, O_NONE));
        s = idle();                                      step(s, ex(4'h0, O_NONE));
        s = idle(); s.mem_req = 1'b1;                    step(s, ex(4'h0, O_START));
        s.sram_done = 1'b1;                              step(s, ex(4'h0, O_FRZ));
        s = idle();                                      step(s, ex(4'h0, O_NONE));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset cyc%0d: got %h want %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_sr();
        in_t s;
        out_t e, o;
        int n = 0;
        s = idle(); s.exe_s = 1'b1; s.alu_status = 4'b0110; step(s, ex(4'h0, O_NONE));
        s = idle(); s.alu_status = 4'b1111;                 step(s, ex(4'h6, O_NONE));
        s = idle();                                         step(s, ex(4'h6, O_NONE));
        s = idle(); s.exe_s = 1'b1; s.alu_status = 4'hA;    step(s, ex(4'h6, O_NONE));
        s = idle();                                         step(s, ex(4'hA, O_NONE));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL sr cyc%0d: got %h want %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_hazard();
        in_t s;
        out_t e, o;
        int n = 0;
        s = idle(); s.id_valid = 1; s.id_src1 = 4'd3; s.exe_dest = 4'd3; s.exe_wb_en = 1;
        step(s, ex(4'hA, O_STALL));
        s = idle(); s.id_valid = 1; s.id_src1 = 4'd1; s.id_src2 = 4'd5; s.exe_dest = 4'd5; s.exe_wb_en = 1;
        step(s, ex(4'hA, O_NONE));
        s.id_two_src = 1;
        step(s, ex(4'hA, O_STALL));
        s = idle(); s.id_valid = 1; s.id_src1 = 4'd1; s.mem_dest = 4'd1; s.mem_wb_en = 1;
        step(s, ex(4'hA, O_STALL));
        s.id_valid = 0;
        step(s, ex(4'hA, O_NONE));
        s = idle(); s.id_valid = 1; s.id_src1 = 4'd7; s.exe_dest = 4'd7;
        step(s, ex(4'hA, O_NONE));
        s = idle(); s.id_valid = 1; s.id_src1 = 4'd2; s.id_src2 = 4'd9; s.id_two_src = 1;
        s.mem_dest = 4'd9; s.mem_wb_en = 1;
        step(s, ex(4'hA, O_STALL));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL hazard cyc%0d: got %h want %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_branch();
        in_t s;
        out_t e, o;
        int n = 0;
        s = idle(); s.br_taken = 1; s.id_valid = 1; s.id_src1 = 4'd3; s.exe_dest = 4'd3; s.exe_wb_en = 1;
        step(s, ex(4'hA, O_FLUSH));
        s = idle(); s.br_taken = 1;
        step(s, ex(4'hA, O_FLUSH));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL branch cyc%0d: got %h want %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_mem_access();
        in_t s;
        out_t e, o;
        int n = 0;
        s = idle(); s.mem_req = 1;        step(s, ex(4'hA, O_START));  // T0
                                          step(s, ex(4'hA, O_FRZ));    // T1
        s.br_taken = 1;                   step(s, ex(4'hA, O_FRZ));    // T2 branch held
        s.sram_done = 1;                  step(s, ex(4'hA, O_FRZ));    // T3
        s.sram_done = 0;                  step(s, ex(4'hA, O_FLUSH));  // T4 DONE, req ignored
        s = idle(); s.sram_done = 1;      step(s, ex(4'hA, O_NONE));   // T5 IDLE, stray done
        s = idle(); s.mem_req = 1;        step(s, ex(4'hA, O_START));
        s.sram_done = 1;                  step(s, ex(4'hA, O_FRZ));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL mem_access cyc%0d: got %h want %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        in_t s;
        out_t e, o;
        int n = 0;
        s = idle(); s.mem_req = 1;        step(s, ex(4'hA, O_NONE));   // DONE of previous access
                                          step(s, ex(4'hA, O_START));  // IDLE relaunches
        s.sram_done = 1;                  step(s, ex(4'hA, O_FRZ));
        s = idle();                       step(s, ex(4'hA, O_NONE));
        s = idle();                       step(s, ex(4'hA, O_NONE));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", n, o, e);
            end
            n++;
        end
    endtask

    task automatic test_timeout();
        in_t s;
        out_t e, o;
        int n = 0;
        s = idle(); s.mem_req = 1;        step(s, ex(4'hA, O_START));
        s.exe_s = 1; s.alu_status = 4'h3;
        for (int i = 0; i < 16; i++) step(s, ex(4'hA, O_FRZ));          // WAIT, counter 0..15
        s.mem_req = 0;                    step(s, ex(4'hA, O_ERR));    // DONE, release edge
        s = idle();                       step(s, ex(4'h3, O_ERR));
                                          step(s, ex(4'h3, O_ERR));
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin
                bad++;
                $display("FAIL timeout cyc%0d: got %h want %h", n, o, e);
            end
            n++;
        end
    endtask

    initial begin
        drive(idle());
        rst_n = 1'b0;
        test_reset();
        test_sr();
        test_hazard();
        test_branch();
        test_mem_access();
        test_back_to_back();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
